// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a byte-lane SRAM, with programmable wait states,
// a two-cycle ERROR response and a read-after-write bypass for pipelined transfers.
module ahb_sram_slave #(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0,
    parameter int INIT_ZERO   = 1
) (
    input  logic        hclk,
    input  logic        hreset_n,
    input  logic        hsel,
    input  logic [77:0] ahb_in,
    output logic [33:0] ahb_out
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // ahb_in = {haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata}
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    assign haddr  = ahb_in[77:46];
    assign htrans = ahb_in[45:44];
    assign hwrite = ahb_in[43];
    assign hsize  = ahb_in[42:40];
    assign hwdata = ahb_in[31:0];

    // Burst/protection/lock fields are not needed by a plain memory; INIT_ZERO only
    // describes the expected power-up contents, no logic ever clears the array.
    logic unused_fields;
    assign unused_fields = ^{ahb_in[39:32], INIT_ZERO[0]};

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] word_q, word_d;
    logic [3:0]    be_q, be_d;
    logic          write_q, write_d;
    logic          rd_valid_q, rd_valid_d;
    logic [31:0]   byp_mask_q, byp_mask_d;
    logic [31:0]   byp_data_q, byp_data_d;

    logic          hreadyout;
    logic          hresp;
    logic [31:0]   hrdata;
    logic          accept;
    logic          legal;
    logic [AW-1:0] in_word;
    logic [3:0]    in_be;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] rd_word;
    logic [31:0]   ram_word;
    logic [31:0]   wr_mask;

    // Ready and response come from state only, so nothing in ahb_in reaches hreadyout.
    assign hreadyout = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign accept    = hsel & htrans[1] & hreadyout;
    assign in_word   = haddr[AW+1:2];

    always_comb begin
        legal = 1'b1;
        if (hsize > 3'b010) begin
            legal = 1'b0;
        end
        if ((hsize == 3'b001) && haddr[0]) begin
            legal = 1'b0;
        end
        if ((hsize == 3'b010) && (haddr[1:0] != 2'b00)) begin
            legal = 1'b0;
        end
        if (haddr[31:2] >= 30'(MEM_DEPTH)) begin
            legal = 1'b0;
        end

        case (hsize)
            3'b000:  in_be = 4'b0001 << haddr[1:0];
            3'b001:  in_be = haddr[1] ? 4'b1100 : 4'b0011;
            default: in_be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        be_d    = be_q;
        write_d = write_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        rd_word = in_word;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_DATA;
                    rd_en   = !write_q;
                    rd_word = word_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DATA: begin
                wr_en   = write_q;
                state_d = ST_IDLE;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        // Accepts only happen while ready, i.e. from IDLE, DATA or ERR2.
        if (accept) begin
            word_d  = in_word;
            be_d    = in_be;
            write_d = hwrite;
            if (!legal) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = WS;
            end else begin
                state_d = ST_DATA;
                rd_en   = !hwrite;
                rd_word = in_word;
            end
        end
    end

    // A read launched on the same edge a write commits to that word sees stale RAM
    // data; remember the written lanes so the output can overlay them.
    always_comb begin
        rd_valid_d = rd_valid_q | rd_en;
        byp_mask_d = byp_mask_q;
        byp_data_d = byp_data_q;
        if (rd_en) begin
            byp_mask_d = (wr_en && (rd_word == word_q)) ? wr_mask : 32'h0;
            byp_data_d = hwdata;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            word_q     <= '0;
            be_q       <= 4'h0;
            write_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            byp_mask_q <= 32'h0;
            byp_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            be_q       <= be_d;
            write_q    <= write_d;
            rd_valid_q <= rd_valid_d;
            byp_mask_q <= byp_mask_d;
            byp_data_q <= byp_data_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [MEM_DEPTH];
        logic [7:0] rd_byte_q;

        always_ff @(posedge hclk) begin
            if (wr_en && be_q[gi]) begin
                mem[word_q] <= hwdata[8*gi +: 8];
            end
            if (rd_en) begin
                rd_byte_q <= mem[rd_word];
            end
        end

        assign ram_word[8*gi +: 8] = rd_byte_q;
        assign wr_mask[8*gi +: 8]  = {8{be_q[gi]}};
    end

    assign hrdata  = rd_valid_q ? ((ram_word & ~byp_mask_q) | (byp_data_q & byp_mask_q)) : 32'h0;
    assign ahb_out = {hreadyout, hrdata, hresp};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 3 wait states), a pipelined bus
// driver, a byte-array reference model and a scoreboard monitor on the response side.
`timescale 1ns/1ps
module tb_ahb_sram_slave;
    localparam int DEPTH  = 64;
    localparam int NBYTES = DEPTH * 4;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    logic        clk = 1'b0;
    logic        hreset_n = 1'b0;
    logic        hsel [2];
    logic [77:0] ahb_in [2];
    logic [33:0] ahb_out [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ahb_sram_slave #(
            .MEM_DEPTH  (DEPTH),
            .WAIT_STATES(3 * gi),
            .INIT_ZERO  (1)
        ) u_dut (
            .hclk    (clk),
            .hreset_n(hreset_n),
            .hsel    (hsel[gi]),
            .ahb_in  (ahb_in[gi]),
            .ahb_out (ahb_out[gi])
        );
    end

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic        is_read;
        logic        err;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] addr;
    } exp_t;

    xfer_t      stim_q [$];
    exp_t       exp_q [$];
    logic [7:0] ref_mem [2][NBYTES];
    int         act = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         mon_waits = 0;
    logic       mon_resp_bad = 1'b0;
    logic       m_rdy, m_resp;
    logic [31:0] m_rd;
    exp_t       m_e;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got %h, expected %h", name, act, got, exp);
        end
    endtask

    function automatic xfer_t mk(logic sel, logic [1:0] tr, logic [31:0] addr,
                                 logic [2:0] size, logic wr, logic [31:0] wd);
        xfer_t x;
        x.sel = sel; x.trans = tr; x.addr = addr; x.size = size; x.write = wr; x.wdata = wd;
        return x;
    endfunction

    task automatic add(logic sel, logic [1:0] tr, logic [31:0] addr,
                       logic [2:0] size, logic wr, logic [31:0] wd);
        stim_q.push_back(mk(sel, tr, addr, size, wr, wd));
    endtask

    task automatic drive_addr(xfer_t x, logic [31:0] wd);
        logic [7:0] side;
        side = 8'($urandom);
        hsel[act]   = x.sel;
        ahb_in[act] = {x.addr, x.trans, x.write, x.size, side, wd};
    endtask

    // Reference model: a flat byte array, updated in program order at accept time.
    function automatic void issue(xfer_t x);
        exp_t e;
        int   base;
        logic legal;
        legal = (x.size <= 3'd2) && ((x.addr % (32'd1 << x.size)) == 32'd0) &&
                (x.addr < 32'(NBYTES));
        base = int'(x.addr & 32'hFFFF);
        e.err     = !legal;
        e.waits   = legal ? ((act == 1) ? 3 : 0) : 1;
        e.is_read = legal && !x.write;
        e.addr    = x.addr;
        e.rdata   = 32'h0;
        if (legal) begin
            if (x.write) begin
                for (int b = 0; b < (1 << x.size); b++)
                    ref_mem[act][base + b] = x.wdata[8 * ((base + b) % 4) +: 8];
            end else begin
                for (int b = 0; b < 4; b++)
                    e.rdata[8 * b +: 8] = ref_mem[act][(base & ~3) + b];
            end
        end
        exp_q.push_back(e);
    endfunction

    task automatic run_stim();
        xfer_t       cur, idle_x;
        logic        cur_v;
        logic        rdy;
        logic [31:0] wd;
        int          guard;
        guard  = 0;
        idle_x = mk(1'b0, HT_IDLE, 32'h0, 3'd0, 1'b0, 32'h0);
        wd     = $urandom;
        @(posedge clk); #1;
        cur_v = (stim_q.size() > 0);
        if (cur_v) cur = stim_q.pop_front();
        if (cur_v) drive_addr(cur, wd); else drive_addr(idle_x, wd);
        while (cur_v || (exp_q.size() > 0)) begin
            @(negedge clk);
            rdy = ahb_out[act][33];
            @(posedge clk); #1;
            if (rdy) begin
                wd = $urandom;
                if (cur_v && cur.sel && cur.trans[1]) begin
                    issue(cur);
                    if (cur.write) wd = cur.wdata;
                end
                cur_v = (stim_q.size() > 0);
                if (cur_v) cur = stim_q.pop_front();
                if (cur_v) drive_addr(cur, wd); else drive_addr(idle_x, wd);
            end
            guard++;
            if (guard > 20000) begin
                n_tests++;
                n_fail++;
                $display("FAIL drv_timeout: got %0d cycles, expected fewer", guard);
                break;
            end
        end
    endtask

    // Scoreboard: the front entry is the data phase in progress.
    always @(negedge clk) begin
        if (hreset_n && (exp_q.size() > 0)) begin
            m_rdy  = ahb_out[act][33];
            m_resp = ahb_out[act][0];
            m_rd   = ahb_out[act][32:1];
            if (!m_rdy) begin
                mon_waits++;
                if (m_resp !== exp_q[0].err) mon_resp_bad = 1'b1;
                if (mon_waits > 40) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wait_timeout: got %0d low cycles, expected %0d", mon_waits, exp_q[0].waits);
                    void'(exp_q.pop_front());
                    mon_waits    = 0;
                    mon_resp_bad = 1'b0;
                end
            end else begin
                m_e = exp_q.pop_front();
                $display("[TB] dut%0d %s addr=%h hresp=%0d waits=%0d hrdata=%h", act,
                         m_e.err ? "err" : (m_e.is_read ? "rd " : "wr "), m_e.addr, m_resp, mon_waits, m_rd);
                check("waits", 64'(mon_waits), 64'(m_e.waits));
                check("hresp", {62'h0, mon_resp_bad, m_resp}, {62'h0, 1'b0, m_e.err});
                if (m_e.is_read) check("hrdata", {32'h0, m_rd}, {32'h0, m_e.rdata});
                mon_waits    = 0;
                mon_resp_bad = 1'b0;
            end
        end
    end

    task automatic fill();
        for (int w = 0; w < DEPTH; w++)
            add(1'b1, HT_NONSEQ, 32'(w * 4), 3'd2, 1'b1, $urandom);
    endtask

    task automatic add_random(int n);
        logic [1:0]  tr;
        logic [2:0]  size;
        logic [31:0] addr;
        int          r;
        for (int i = 0; i < n; i++) begin
            r    = $urandom_range(0, 9);
            tr   = (r == 0) ? HT_IDLE : (r == 1) ? HT_BUSY : (r < 6) ? HT_NONSEQ : HT_SEQ;
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 9) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            r = $urandom_range(0, 19);
            if (r == 0) addr = 32'(NBYTES) + 32'($urandom_range(0, 4095));
            if (r == 1) addr = 32'h8000_0000 | 32'($urandom);
            add($urandom_range(0, 9) != 0, tr, addr, size, 1'($urandom_range(0, 1)), $urandom);
        end
    endtask

    task automatic reset_during_wait();
        xfer_t       x;
        logic [31:0] a;
        logic [31:0] old_w;
        a = 32'h40;
        for (int b = 0; b < 4; b++) old_w[8 * b +: 8] = ref_mem[1][int'(a) + b];
        @(posedge clk); #1;
        x = mk(1'b1, HT_NONSEQ, a, 3'd2, 1'b1, 32'h0);
        drive_addr(x, $urandom);
        @(posedge clk); #1;
        x = mk(1'b0, HT_IDLE, 32'h0, 3'd0, 1'b0, 32'h0);
        drive_addr(x, ~old_w);
        @(posedge clk); #1;
        check("wait_ready_low", 64'(ahb_out[1][33]), 64'd0);
        #2 hreset_n = 1'b0;
        #1;
        check("rst_hreadyout", 64'(ahb_out[1][33]), 64'd1);
        check("rst_hresp", 64'(ahb_out[1][0]), 64'd0);
        check("rst_hrdata", 64'(ahb_out[1][32:1]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        hreset_n = 1'b1;
        add(1'b1, HT_NONSEQ, a, 3'd2, 1'b0, 32'h0);
        run_stim();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            hsel[d]   = 1'b0;
            ahb_in[d] = '0;
        end
        hreset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            act = d;
            check("reset_out", 64'(ahb_out[d]), {30'h0, 1'b1, 32'h0, 1'b0});
        end
        @(negedge clk);
        hreset_n = 1'b1;

        // Zero-wait instance.
        act = 0;
        fill();
        run_stim();
        add(1'b1, HT_NONSEQ, 32'h10, 3'd2, 1'b1, 32'hDEADBEEF);
        add(1'b1, HT_NONSEQ, 32'h10, 3'd2, 1'b0, 32'h0);
        add(1'b1, HT_NONSEQ, 32'h10, 3'd2, 1'b1, 32'h11223344);
        add(1'b1, HT_NONSEQ, 32'h13, 3'd0, 1'b1, {8'hAA, 24'($urandom)});
        add(1'b1, HT_NONSEQ, 32'h10, 3'd2, 1'b0, 32'h0);
        add(1'b1, HT_NONSEQ, 32'h02, 3'd2, 1'b1, 32'h55AA55AA);
        add(1'b1, HT_NONSEQ, 32'(NBYTES), 3'd2, 1'b1, 32'h12345678);
        add(1'b1, HT_NONSEQ, 32'h04, 3'd3, 1'b1, 32'h0BADF00D);
        add(1'b1, HT_NONSEQ, 32'h00, 3'd2, 1'b0, 32'h0);
        add(1'b1, HT_NONSEQ, 32'h04, 3'd2, 1'b0, 32'h0);
        add(1'b1, HT_NONSEQ, 32'h20, 3'd2, 1'b1, $urandom);
        add(1'b1, HT_BUSY,   32'h24, 3'd2, 1'b1, $urandom);
        add(1'b1, HT_SEQ,    32'h24, 3'd2, 1'b1, $urandom);
        add(1'b1, HT_IDLE,   32'h28, 3'd2, 1'b1, $urandom);
        add(1'b1, HT_SEQ,    32'h28, 3'd2, 1'b1, $urandom);
        add(1'b0, HT_NONSEQ, 32'h2C, 3'd2, 1'b1, $urandom);
        for (int w = 8; w < 12; w++) add(1'b1, HT_NONSEQ, 32'(w * 4), 3'd2, 1'b0, 32'h0);
        run_stim();
        add_random(200);
        run_stim();

        // Three-wait instance.
        act = 1;
        fill();
        run_stim();
        add(1'b1, HT_NONSEQ, 32'h10, 3'd2, 1'b0, 32'h0);
        add(1'b1, HT_NONSEQ, 32'h02, 3'd2, 1'b1, 32'h55AA55AA);
        add(1'b1, HT_NONSEQ, 32'(NBYTES), 3'd2, 1'b1, 32'h12345678);
        add(1'b1, HT_NONSEQ, 32'h00, 3'd2, 1'b0, 32'h0);
        add(1'b1, HT_NONSEQ, 32'h12, 3'd1, 1'b1, 32'hBEEF0000);
        add(1'b1, HT_NONSEQ, 32'h10, 3'd2, 1'b0, 32'h0);
        run_stim();
        add_random(80);
        run_stim();
        reset_during_wait();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
